// File: rtl/bsg_source_sync_calib_pkg.sv
// Shared definitions for the source-synchronous link calibration sequencer.
//   calib_state_e   : sequencer FSM states
//   calib_popcount  : count of set bits in a channel mask (zero-extended to
//                     calib_max_channels_gp bits by the caller)
package bsg_source_sync_calib_pkg;

  typedef enum logic [2:0] {
    eIdle,
    ePrepare,
    eTest,
    eDone,
    eFail
  } calib_state_e;

  // Widest channel mask the popcount helper accepts.
  localparam int calib_max_channels_gp = 64;

  function automatic int unsigned calib_popcount(input logic [calib_max_channels_gp-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < calib_max_channels_gp; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/bsg_source_sync_calib_timer.sv
// Loadable down-counter shared by the prepare window and the per-row timeout.
//   clk_i, reset_i : clock, async active-high reset (count returns to 0)
//   load_i         : load load_val_i (has priority over decrement)
//   load_val_i     : value to load
//   dec_i          : decrement request; saturates at zero
//   zero_o         : count is zero
module bsg_source_sync_calib_timer
  import bsg_source_sync_calib_pkg::*;
#(
  parameter int width_p = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) count_d = load_val_i;
    else if (dec_i && (count_q != '0)) count_d = count_q - width_p'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/bsg_source_sync_channel_calib_sequencer.sv
// Master-side calibration sequencer for the source-synchronous link.
// Walks tests_p calibration rows plus a final done row. Each row is preceded
// by a prepare window of prepare_cycles_p cycles and bounded by a timeout of
// timeout_cycles_p cycles; channels that have not passed a row by its timeout
// are dropped from the active mask. Too few survivors aborts with fail.
//   clk_i, reset_i     : clock, async active-high reset
//   start_i            : kick off the sequence (only looked at in IDLE)
//   test_scoreboard_i  : [row][channel] pass flags from the channel masters
//   test_index_r_o     : current row index
//   prepare_o          : prepare strobe to the masters
//   channel_active_r_o : surviving channel mask
//   done_o, fail_o     : sticky terminal status
// link_channels_p must not exceed calib_max_channels_gp.
module bsg_source_sync_channel_calib_sequencer
  import bsg_source_sync_calib_pkg::*;
#(
  parameter int link_channels_p  = 4,
  parameter int tests_p          = 2,
  parameter int prepare_cycles_p = 4,
  parameter int timeout_cycles_p = 16,
  parameter int min_channels_p   = 1,
  localparam int idx_w_lp        = (tests_p > 0) ? $clog2(tests_p+1) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    start_i,
  input  logic [tests_p:0][link_channels_p-1:0]   test_scoreboard_i,
  output logic [idx_w_lp-1:0]                     test_index_r_o,
  output logic                                    prepare_o,
  output logic [link_channels_p-1:0]              channel_active_r_o,
  output logic                                    done_o,
  output logic                                    fail_o
);

  localparam int max_cyc_lp = (prepare_cycles_p > timeout_cycles_p) ? prepare_cycles_p
                                                                     : timeout_cycles_p;
  localparam int cnt_w_lp   = $clog2(max_cyc_lp+1);
  localparam logic [cnt_w_lp-1:0] prep_load_lp = cnt_w_lp'(prepare_cycles_p-1);
  localparam logic [cnt_w_lp-1:0] tout_load_lp = cnt_w_lp'(timeout_cycles_p-1);
  localparam logic [idx_w_lp-1:0] last_idx_lp  = idx_w_lp'(tests_p);

  calib_state_e                  state_q, state_d;
  logic [idx_w_lp-1:0]           idx_q, idx_d;
  logic [link_channels_p-1:0]    mask_q, mask_d;
  logic                          tmr_load, tmr_dec, tmr_zero;
  logic [cnt_w_lp-1:0]           tmr_val;

  logic [link_channels_p-1:0]    row, new_mask;
  logic [calib_max_channels_gp-1:0] new_mask_ext;
  logic                          pass;

  bsg_source_sync_calib_timer #(.width_p(cnt_w_lp)) timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Dropped channels count as passing so they cannot stall later rows.
  assign row      = test_scoreboard_i[idx_q];
  assign pass     = &(row | ~mask_q);
  assign new_mask = mask_q & row;

  always_comb begin
    new_mask_ext = '0;
    new_mask_ext[link_channels_p-1:0] = new_mask;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      eIdle: begin
        if (start_i) begin
          state_d  = ePrepare;
          tmr_load = 1'b1;
          tmr_val  = prep_load_lp;
        end
      end
      ePrepare: begin
        if (tmr_zero) begin
          state_d  = eTest;
          tmr_load = 1'b1;
          tmr_val  = tout_load_lp;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      eTest: begin
        // A pass on the last timeout cycle wins over the timeout.
        if (pass || tmr_zero) begin
          if (!pass) mask_d = new_mask;
          if (!pass && (int'(calib_popcount(new_mask_ext)) < min_channels_p)) begin
            state_d = eFail;
          end else if (idx_q == last_idx_lp) begin
            state_d = eDone;
          end else begin
            idx_d    = idx_q + idx_w_lp'(1);
            state_d  = ePrepare;
            tmr_load = 1'b1;
            tmr_val  = prep_load_lp;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      eDone, eFail: ;
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      idx_q   <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

  assign test_index_r_o     = idx_q;
  assign channel_active_r_o = mask_q;
  assign prepare_o          = (state_q == ePrepare);
  assign done_o             = (state_q == eDone);
  assign fail_o             = (state_q == eFail);

endmodule

// File: tb/tb_bsg_source_sync_channel_calib_sequencer.sv
// Scoreboard bench: stimulus pushes each expected output change (with the
// cycle it must appear in, or -1 for "any cycle") before driving inputs; the
// monitor samples outputs on the falling edge and pops/compares on every change.
module tb_bsg_source_sync_channel_calib_sequencer;

  localparam int LC = 4, TP = 2, PC = 4, TO = 16, MC = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [TP:0][LC-1:0] sb = '0;
  logic [1:0]    idx;
  logic          prep, done, fail;
  logic [LC-1:0] mask;

  bsg_source_sync_channel_calib_sequencer #(
    .link_channels_p(LC), .tests_p(TP), .prepare_cycles_p(PC),
    .timeout_cycles_p(TO), .min_channels_p(MC)
  ) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .test_scoreboard_i(sb),
    .test_index_r_o(idx), .prepare_o(prep), .channel_active_r_o(mask),
    .done_o(done), .fail_o(fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       p;
    logic [1:0] i;
    logic [3:0] m;
    logic       d;
    logic       f;
  } obs_t;
  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;

  function automatic void push(int c, logic p, logic [1:0] i, logic [3:0] m, logic d, logic f);
    exp_t e;
    e.cyc = c;
    e.v   = {p, i, m, d, f};
    q.push_back(e);
  endfunction

  // Monitor
  obs_t prev = 'x, cur;
  exp_t e;
  always @(negedge clk) begin
    cur = {prep, idx, mask, done, fail};
    if (cur !== prev) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got p=%b i=%0d m=%b d=%b f=%b",
                 cyc, cur.p, cur.i, cur.m, cur.d, cur.f);
      end else begin
        e = q.pop_front();
        if (cur !== e.v || (e.cyc >= 0 && e.cyc != cyc)) begin
          bad++;
          $display("FAIL output_change cyc=%0d got p=%b i=%0d m=%b d=%b f=%b exp cyc=%0d p=%b i=%0d m=%b d=%b f=%b",
                   cyc, cur.p, cur.i, cur.m, cur.d, cur.f,
                   e.cyc, e.v.p, e.v.i, e.v.m, e.v.d, e.v.f);
        end
      end
      prev = cur;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_until(int c);
    int n = 0;
    while (cyc < c && n < 2000) begin step(); n++; end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin step(); n++; end
    step();
  endtask

  task automatic do_reset();
    push(-1, 1'b0, 2'd0, 4'hF, 1'b0, 1'b0);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    step();
  endtask

  // Full pass with no drops: t0 is the first prepare cycle.
  task automatic push_allpass(int t0);
    push(t0,      1, 0, 4'hF, 0, 0);
    push(t0 + 4,  0, 0, 4'hF, 0, 0);
    push(t0 + 5,  1, 1, 4'hF, 0, 0);
    push(t0 + 9,  0, 1, 4'hF, 0, 0);
    push(t0 + 10, 1, 2, 4'hF, 0, 0);
    push(t0 + 14, 0, 2, 4'hF, 0, 0);
    push(t0 + 15, 0, 2, 4'hF, 1, 0);
  endtask

  int t0;

  initial begin
    push(-1, 1'b0, 2'd0, 4'hF, 1'b0, 1'b0);   // reset state
    step(); step();
    rst = 1'b0;
    step();

    // All channels pass immediately; scoreboard already high during prepare.
    sb = {4'hF, 4'hF, 4'hF};
    t0 = cyc + 1;
    push_allpass(t0);
    go();
    drain();
    do_reset();

    // Channel 3 never passes test 1; start pulsed mid-TEST must be ignored.
    sb = {4'h7, 4'h7, 4'hF};
    t0 = cyc + 1;
    push(t0,      1, 0, 4'hF, 0, 0);
    push(t0 + 4,  0, 0, 4'hF, 0, 0);
    push(t0 + 5,  1, 1, 4'hF, 0, 0);
    push(t0 + 9,  0, 1, 4'hF, 0, 0);
    push(t0 + 25, 1, 2, 4'h7, 0, 0);
    push(t0 + 29, 0, 2, 4'h7, 0, 0);
    push(t0 + 30, 0, 2, 4'h7, 1, 0);
    go();
    wait_until(t0 + 12);
    go();
    drain();
    do_reset();

    // Channels 1-3 fail test 0: only one survivor, abort.
    sb = {4'h0, 4'h0, 4'h1};
    t0 = cyc + 1;
    push(t0,      1, 0, 4'hF, 0, 0);
    push(t0 + 4,  0, 0, 4'hF, 0, 0);
    push(t0 + 20, 0, 0, 4'h1, 0, 1);
    go();
    drain();
    repeat (5) step();
    do_reset();

    // Pass arrives on the 16th (last) TEST cycle of row 0.
    sb = '0;
    t0 = cyc + 1;
    push(t0,      1, 0, 4'hF, 0, 0);
    push(t0 + 4,  0, 0, 4'hF, 0, 0);
    push(t0 + 20, 1, 1, 4'hF, 0, 0);
    push(t0 + 24, 0, 1, 4'hF, 0, 0);
    push(t0 + 25, 1, 2, 4'hF, 0, 0);
    push(t0 + 29, 0, 2, 4'hF, 0, 0);
    push(t0 + 30, 0, 2, 4'hF, 1, 0);
    go();
    wait_until(t0 + 19);
    sb = {4'hF, 4'hF, 4'hF};
    drain();
    do_reset();

    // Async reset in the middle of test 1's prepare, then a fresh start.
    sb = {4'hF, 4'hF, 4'hF};
    t0 = cyc + 1;
    push(t0,      1, 0, 4'hF, 0, 0);
    push(t0 + 4,  0, 0, 4'hF, 0, 0);
    push(t0 + 5,  1, 1, 4'hF, 0, 0);
    push(t0 + 6,  0, 0, 4'hF, 0, 0);   // must show before the next rising edge
    go();
    wait_until(t0 + 5);
    @(posedge clk);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    t0 = cyc + 1;
    push_allpass(t0);
    go();
    drain();

    repeat (10) step();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drained remaining=%0d required=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
